// File: rtl/rx_data_phase_ctrl_if.sv
// Signal bundle between the receive data-phase controller and its token decoder,
// crc16 receive stage, transfer layer and TX handshake generator.
interface rx_data_phase_ctrl_if;
    logic        token_valid;
    logic        token_setup;
    logic        ep_buf_ready;
    logic        rx_sop_en;
    logic [7:0]  rx_data;
    logic        rx_lt_valid;
    logic        rx_lt_ready;
    logic        rx_lt_eop_en;
    logic        rx_crc16_err;
    logic        hs_ready;
    logic        rx_data_on;
    logic        hs_valid;
    logic [3:0]  hs_pid;
    logic        data_toggle;
    logic [10:0] rx_byte_cnt;
    logic        pkt_done;
    logic        err_timeout;
    logic        err_crc;
    logic        err_babble;

    // Controller side.
    modport slave (
        input  token_valid, token_setup, ep_buf_ready, rx_sop_en, rx_data,
               rx_lt_valid, rx_lt_ready, rx_lt_eop_en, rx_crc16_err, hs_ready,
        output rx_data_on, hs_valid, hs_pid, data_toggle, rx_byte_cnt,
               pkt_done, err_timeout, err_crc, err_babble
    );

    // Environment side.
    modport master (
        output token_valid, token_setup, ep_buf_ready, rx_sop_en, rx_data,
               rx_lt_valid, rx_lt_ready, rx_lt_eop_en, rx_crc16_err, hs_ready,
        input  rx_data_on, hs_valid, hs_pid, data_toggle, rx_byte_cnt,
               pkt_done, err_timeout, err_crc, err_babble
    );
endinterface

// File: rtl/rx_data_phase_ctrl.sv
// USB device OUT/SETUP data-phase controller: waits for the DATA packet after a
// token, counts beats, checks toggle/CRC/babble and requests the ACK/NAK handshake.
module rx_data_phase_ctrl #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd720,
    parameter logic [10:0] MAX_PKT     = 11'd64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rx_data_phase_ctrl_if.slave  bus
);
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [1:0] {IDLE, WAIT_SOP, DATA, HS} state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic        nak_flag_q;
    logic        pid_bit_q;
    logic        rx_data_on_q;
    logic        hs_valid_q;
    logic [3:0]  hs_pid_q;
    logic        data_toggle_q;
    logic [10:0] rx_byte_cnt_q;
    logic        pkt_done_q;
    logic        err_timeout_q;
    logic        err_crc_q;
    logic        err_babble_q;

    logic [10:0] rx_byte_cnt_d;
    logic        babble;
    logic        timeout_hit;
    logic        pid_ok;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_byte_cnt_d = rx_byte_cnt_q;
        if (bus.rx_lt_valid && bus.rx_lt_ready && (rx_byte_cnt_q != 11'h7FF))
            rx_byte_cnt_d = rx_byte_cnt_q + 11'd1;
    end

    // Babble is judged on the count including the EOP beat itself.
    assign babble      = rx_byte_cnt_d > (MAX_PKT + 11'd3);
    assign timeout_hit = timer_q == (TIMEOUT_CYC - 16'd1);
    assign pid_ok      = (bus.rx_data[3:0] == PID_DATA0) || (bus.rx_data[3:0] == PID_DATA1);

    // NOTE: all state and registered outputs update with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            nak_flag_q    <= 1'b0;
            pid_bit_q     <= 1'b0;
            rx_data_on_q  <= 1'b0;
            hs_valid_q    <= 1'b0;
            hs_pid_q      <= '0;
            data_toggle_q <= 1'b0;
            rx_byte_cnt_q <= '0;
            pkt_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_crc_q     <= 1'b0;
            err_babble_q  <= 1'b0;
        end else begin
            pkt_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_crc_q     <= 1'b0;
            err_babble_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.token_valid) begin
                        state_q       <= WAIT_SOP;
                        timer_q       <= '0;
                        nak_flag_q    <= !bus.ep_buf_ready;
                        rx_byte_cnt_q <= '0;
                        rx_data_on_q  <= 1'b1;
                        if (bus.token_setup) data_toggle_q <= 1'b0;
                    end
                end
                WAIT_SOP: begin
                    if (bus.rx_sop_en) begin
                        timer_q <= '0;
                        if (pid_ok) begin
                            state_q   <= DATA;
                            pid_bit_q <= bus.rx_data[3];
                        end else begin
                            state_q      <= IDLE;
                            rx_data_on_q <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        timer_q       <= '0;
                        rx_data_on_q  <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                DATA: begin
                    rx_byte_cnt_q <= rx_byte_cnt_d;
                    if (bus.rx_lt_eop_en) begin
                        timer_q      <= '0;
                        rx_data_on_q <= 1'b0;
                        if (bus.rx_crc16_err) begin
                            state_q   <= IDLE;
                            err_crc_q <= 1'b1;
                        end else if (babble) begin
                            state_q      <= IDLE;
                            err_babble_q <= 1'b1;
                        end else begin
                            state_q    <= HS;
                            hs_valid_q <= 1'b1;
                            if (nak_flag_q) begin
                                hs_pid_q <= PID_NAK;
                            end else begin
                                hs_pid_q <= PID_ACK;
                                // A repeated packet (toggle mismatch) is ACKed but not delivered.
                                if (pid_bit_q == data_toggle_q) begin
                                    data_toggle_q <= !data_toggle_q;
                                    pkt_done_q    <= 1'b1;
                                end
                            end
                        end
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        timer_q       <= '0;
                        rx_data_on_q  <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                HS: begin
                    if (bus.hs_ready) begin
                        state_q    <= IDLE;
                        hs_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data_on  = rx_data_on_q;
    assign bus.hs_valid    = hs_valid_q;
    assign bus.hs_pid      = hs_pid_q;
    assign bus.data_toggle = data_toggle_q;
    assign bus.rx_byte_cnt = rx_byte_cnt_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_crc     = err_crc_q;
    assign bus.err_babble  = err_babble_q;
endmodule

// File: tb/tb_rx_data_phase_ctrl.sv
// Directed bench for rx_data_phase_ctrl: a linear sequence of packets with
// hand-computed handshake, toggle, count and error-pulse expectations.
module tb_rx_data_phase_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rx_data_phase_ctrl_if bus ();

    rx_data_phase_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_token(input logic setup, input logic buf_ready);
        bus.token_valid  = 1'b1;
        bus.token_setup  = setup;
        bus.ep_buf_ready = buf_ready;
        tick();
        bus.token_valid  = 1'b0;
        bus.token_setup  = 1'b0;
        bus.ep_buf_ready = 1'b1;
    endtask

    task automatic send_sop(input logic [3:0] pid);
        bus.rx_sop_en = 1'b1;
        bus.rx_data   = {4'h0, pid};
        tick();
        bus.rx_sop_en = 1'b0;
        bus.rx_data   = 8'h00;
    endtask

    task automatic send_beats(input int n, input logic with_eop, input logic crc_err);
        for (int i = 0; i < n; i++) begin
            bus.rx_lt_valid  = 1'b1;
            bus.rx_lt_ready  = 1'b1;
            bus.rx_lt_eop_en = with_eop && (i == n - 1);
            bus.rx_crc16_err = crc_err && (i == n - 1);
            bus.rx_data      = i[7:0];
            tick();
        end
        bus.rx_lt_valid  = 1'b0;
        bus.rx_lt_ready  = 1'b0;
        bus.rx_lt_eop_en = 1'b0;
        bus.rx_crc16_err = 1'b0;
        bus.rx_data      = 8'h00;
    endtask

    task automatic accept_hs(input string tag);
        bus.hs_ready = 1'b1;
        tick();
        bus.hs_ready = 1'b0;
        check({tag, "_hs_released"}, bus.hs_valid, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.token_valid  = 1'b0;
        bus.token_setup  = 1'b0;
        bus.ep_buf_ready = 1'b1;
        bus.rx_sop_en    = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rx_lt_valid  = 1'b0;
        bus.rx_lt_ready  = 1'b0;
        bus.rx_lt_eop_en = 1'b0;
        bus.rx_crc16_err = 1'b0;
        bus.hs_ready     = 1'b0;
        tick();
        tick();
        check("rst_rx_data_on", bus.rx_data_on, 0);
        check("rst_hs_valid", bus.hs_valid, 0);
        check("rst_hs_pid", bus.hs_pid, 0);
        check("rst_toggle", bus.data_toggle, 0);
        check("rst_cnt", bus.rx_byte_cnt, 0);
        check("rst_pulses", {bus.pkt_done, bus.err_timeout, bus.err_crc, bus.err_babble}, 0);
        rst_n = 1'b1;
        tick();

        // Good DATA0 with toggle 0: ACK, toggle flips, packet delivered.
        send_token(1'b0, 1'b1);
        check("s1_rx_data_on", bus.rx_data_on, 1);
        send_sop(4'h3);
        send_beats(10, 1'b1, 1'b0);
        check("s1_hs_valid", bus.hs_valid, 1);
        check("s1_hs_pid", bus.hs_pid, 4'b0010);
        check("s1_toggle", bus.data_toggle, 1);
        check("s1_pkt_done", bus.pkt_done, 1);
        check("s1_cnt", bus.rx_byte_cnt, 10);
        check("s1_rx_data_off", bus.rx_data_on, 0);
        accept_hs("s1");
        check("s1_pkt_done_1cyc", bus.pkt_done, 0);

        // Repeated DATA0 while expecting DATA1: ACK, no delivery.
        send_token(1'b0, 1'b1);
        send_sop(4'h3);
        send_beats(5, 1'b1, 1'b0);
        check("s2_hs_pid", bus.hs_pid, 4'b0010);
        check("s2_toggle", bus.data_toggle, 1);
        check("s2_pkt_done", bus.pkt_done, 0);
        check("s2_cnt", bus.rx_byte_cnt, 5);
        accept_hs("s2");

        // Buffer not ready: NAK held stable while TX is busy.
        send_token(1'b0, 1'b0);
        send_sop(4'hB);
        send_beats(4, 1'b1, 1'b0);
        check("s3_pkt_done", bus.pkt_done, 0);
        for (int i = 0; i < 5; i++) begin
            check("s3_hold_valid", bus.hs_valid, 1);
            check("s3_hold_pid", bus.hs_pid, 4'b1010);
            tick();
        end
        check("s3_toggle", bus.data_toggle, 1);
        accept_hs("s3");

        // No SOP: timeout on the 720th cycle after the token.
        send_token(1'b0, 1'b1);
        for (int i = 0; i < 719; i++) tick();
        check("s4_no_early_timeout", bus.err_timeout, 0);
        check("s4_still_on", bus.rx_data_on, 1);
        tick();
        check("s4_err_timeout", bus.err_timeout, 1);
        check("s4_rx_data_off", bus.rx_data_on, 0);
        check("s4_no_hs", bus.hs_valid, 0);
        tick();
        check("s4_timeout_1cyc", bus.err_timeout, 0);

        // EOP on the same cycle the DATA timer expires wins over the timeout.
        send_token(1'b0, 1'b1);
        send_sop(4'hB);
        for (int i = 0; i < 719; i++) tick();
        send_beats(1, 1'b1, 1'b0);
        check("s5_no_timeout", bus.err_timeout, 0);
        check("s5_hs_valid", bus.hs_valid, 1);
        check("s5_toggle", bus.data_toggle, 0);
        check("s5_pkt_done", bus.pkt_done, 1);
        accept_hs("s5");

        // CRC error: err_crc, no handshake, toggle kept.
        send_token(1'b0, 1'b1);
        send_sop(4'h3);
        send_beats(4, 1'b1, 1'b1);
        check("s6_err_crc", bus.err_crc, 1);
        check("s6_no_hs", bus.hs_valid, 0);
        check("s6_toggle", bus.data_toggle, 0);
        check("s6_rx_data_off", bus.rx_data_on, 0);
        tick();
        check("s6_crc_1cyc", bus.err_crc, 0);

        // Non-DATA PID after the token: silent return to IDLE.
        send_token(1'b0, 1'b1);
        send_sop(4'h2);
        check("s7_rx_data_off", bus.rx_data_on, 0);
        check("s7_no_hs", bus.hs_valid, 0);
        tick();
        check("s7_no_pulses", {bus.pkt_done, bus.err_timeout, bus.err_crc, bus.err_babble}, 0);

        // 70 beats exceed 64+3: babble.
        send_token(1'b0, 1'b1);
        send_sop(4'h3);
        send_beats(70, 1'b1, 1'b0);
        check("s8_err_babble", bus.err_babble, 1);
        check("s8_no_hs", bus.hs_valid, 0);
        check("s8_cnt", bus.rx_byte_cnt, 70);
        check("s8_toggle", bus.data_toggle, 0);
        tick();
        check("s8_babble_1cyc", bus.err_babble, 0);

        // 67 beats is a full-size packet, not babble.
        send_token(1'b0, 1'b1);
        send_sop(4'h3);
        send_beats(67, 1'b1, 1'b0);
        check("s9_no_babble", bus.err_babble, 0);
        check("s9_hs_pid", bus.hs_pid, 4'b0010);
        check("s9_cnt", bus.rx_byte_cnt, 67);
        check("s9_toggle", bus.data_toggle, 1);
        accept_hs("s9");

        // SETUP forces DATA0 expectation.
        send_token(1'b1, 1'b1);
        check("s10_setup_toggle", bus.data_toggle, 0);
        send_sop(4'h3);
        send_beats(3, 1'b1, 1'b0);
        check("s10_pkt_done", bus.pkt_done, 1);
        check("s10_toggle", bus.data_toggle, 1);
        accept_hs("s10");

        // Token and SOP arriving during DATA are ignored.
        send_token(1'b0, 1'b1);
        send_sop(4'hB);
        bus.token_valid  = 1'b1;
        bus.token_setup  = 1'b1;
        bus.ep_buf_ready = 1'b0;
        bus.rx_sop_en    = 1'b1;
        bus.rx_data      = 8'h03;
        tick();
        bus.token_valid  = 1'b0;
        bus.token_setup  = 1'b0;
        bus.ep_buf_ready = 1'b1;
        bus.rx_sop_en    = 1'b0;
        send_beats(3, 1'b1, 1'b0);
        check("s11_hs_pid", bus.hs_pid, 4'b0010);
        check("s11_toggle", bus.data_toggle, 0);
        check("s11_pkt_done", bus.pkt_done, 1);
        check("s11_cnt", bus.rx_byte_cnt, 3);
        accept_hs("s11");

        // Reset mid-packet aborts; the next transfer runs normally.
        send_token(1'b0, 1'b1);
        send_sop(4'h3);
        send_beats(3, 1'b0, 1'b0);
        check("s12_cnt_pre", bus.rx_byte_cnt, 3);
        rst_n = 1'b0;
        #1;
        check("s12_rst_cnt", bus.rx_byte_cnt, 0);
        check("s12_rst_on", bus.rx_data_on, 0);
        check("s12_rst_hs", bus.hs_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("s12_no_pulses", {bus.pkt_done, bus.err_timeout, bus.err_crc, bus.err_babble}, 0);
        send_token(1'b0, 1'b1);
        send_sop(4'h3);
        send_beats(2, 1'b1, 1'b0);
        check("s12_hs_pid", bus.hs_pid, 4'b0010);
        check("s12_toggle", bus.data_toggle, 1);
        check("s12_pkt_done", bus.pkt_done, 1);
        check("s12_cnt", bus.rx_byte_cnt, 2);
        accept_hs("s12");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_data_phase_ctrl.md
RX_DATA_PHASE_CTRL -- requirements
Module: rx_data_phase_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd720, which is the bus-turnaround timeout in clk cycles.
REQ-002 SHALL have parameter MAX_PKT, default 11'd64, which is the max payload bytes per DATA packet.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port token_valid, input, 1 bit: pulse, OUT/SETUP token for this device decoded with good CRC5.
REQ-006 SHALL have port token_setup, input, 1 bit: qualifies token_valid; 1 means SETUP.
REQ-007 SHALL have port ep_buf_ready, input, 1 bit: endpoint buffer can accept a packet; sampled with token_valid.
REQ-008 SHALL have port rx_sop_en, input, 1 bit: pulse, DATA SOP beat accepted by crc16 stage.
REQ-009 SHALL have port rx_data, input, 8 bits: receive byte; bits [3:0] are the PID when rx_sop_en=1.
REQ-010 SHALL have port rx_lt_valid, input, 1 bit: beat valid toward transfer layer.
REQ-011 SHALL have port rx_lt_ready, input, 1 bit: transfer layer ready.
REQ-012 SHALL have port rx_lt_eop_en, input, 1 bit: pulse, DATA EOP beat delivered to transfer layer.
REQ-013 SHALL have port rx_crc16_err, input, 1 bit: CRC16 failure; valid in the rx_lt_eop_en cycle.
REQ-014 SHALL have port hs_ready, input, 1 bit: TX side accepts handshake request.
REQ-015 SHALL have port rx_data_on, output, 1 bit: enables crc16 receive stage.
REQ-016 SHALL have port hs_valid, output, 1 bit: handshake request.
REQ-017 SHALL have port hs_pid, output, 4 bits: handshake PID; ACK=4'b0010, NAK=4'b1010.
REQ-018 SHALL have port data_toggle, output, 1 bit: expected DATA PID (0=DATA0, 1=DATA1).
REQ-019 SHALL have port rx_byte_cnt, output, 11 bits: beats of current packet.
REQ-020 SHALL have ports pkt_done, err_timeout, err_crc and err_babble, each output, 1 bit, single-cycle pulses.

Function
REQ-021 SHALL implement FSM states IDLE, WAIT_SOP, DATA and HS, all registered.
REQ-022 In IDLE, token_valid=1 SHALL cause: go to WAIT_SOP; latch nak_flag=!ep_buf_ready; clear rx_byte_cnt; if token_setup=1, force data_toggle to 0.
REQ-023 SHALL drive rx_data_on=1 exactly in WAIT_SOP and DATA, registered, asserted the cycle after token_valid.
REQ-024 SHALL clear the 16-bit timer on every state entry; it increments each cycle in WAIT_SOP and DATA.
REQ-025 When the timer equals TIMEOUT_CYC-1 and no exiting event occurs, SHALL pulse err_timeout and go to IDLE, with no handshake.
REQ-026 In WAIT_SOP, rx_sop_en=1 with rx_data[3:0] of 4'b0011 or 4'b1011 SHALL go to DATA and latch pid_bit=rx_data[3]; any other PID SHALL go to IDLE silently.
REQ-027 In DATA, each cycle with rx_lt_valid&&rx_lt_ready SHALL increment rx_byte_cnt, including the SOP/PID and CRC beats, saturating at 2047.
REQ-028 babble SHALL be defined as rx_byte_cnt > MAX_PKT+3.
REQ-029 In DATA, on rx_lt_eop_en the following priority SHALL apply:
- crc error -> pulse err_crc, go to IDLE;
- else babble -> pulse err_babble, go to IDLE;
- else nak_flag -> HS with NAK;
- else pid_bit!=data_toggle -> HS with ACK, no toggle change, no pkt_done;
- else -> HS with ACK, data_toggle flips, pkt_done pulses.
REQ-030 rx_lt_eop_en SHALL take priority over a timeout in the same cycle.
REQ-031 In HS, hs_valid=1 and hs_pid SHALL be held stable until hs_ready=1; go to IDLE the cycle after acceptance; no timeout in HS.
REQ-032 token_valid SHALL be ignored outside IDLE; rx_sop_en and rx_lt_eop_en SHALL be ignored outside WAIT_SOP and DATA respectively.
REQ-033 All outputs SHALL be registered; the pulse outputs SHALL be high for exactly one cycle, the cycle after the decision.

Reset
REQ-034 On rst_n=0, SHALL set state=IDLE and rx_data_on=0, hs_valid=0, hs_pid=0, data_toggle=0, rx_byte_cnt=0, all pulses=0, timer=0, nak_flag=0, pid_bit=0.
REQ-035 Reset mid-packet or mid-handshake SHALL abort immediately, with no pulse emitted after release.

Verification
REQ-036 Scenario: OUT token, ep_buf_ready=1, DATA0 PID 4'h3, 10 beats, eop with crc ok -> hs ACK, data_toggle 0->1, pkt_done=1, rx_byte_cnt=10.
REQ-037 Scenario: repeat with DATA0 while data_toggle=1 -> ACK, toggle stays 1, no pkt_done.
REQ-038 Scenario: token with ep_buf_ready=0, good DATA1 -> hs_pid=4'b1010, toggle unchanged; hold hs_ready=0 for 5 cycles -> hs_valid/hs_pid stable.
REQ-039 Scenario: token, no SOP for 720 cycles -> err_timeout at cycle 720, rx_data_on=0, no hs_valid; eop+crc_err -> err_crc, no hs.
REQ-040 Scenario: 70 beats with MAX_PKT=64 -> err_babble, no hs; SETUP token when toggle=1 -> toggle=0.
REQ-041 Scenario: rst_n low during DATA -> all outputs reset values; next token works normally.
